// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: icache vs dcache onto a single RAM port.
// The dcache wins contention, but icache is granted after STARVE_MAX consecutive dcache wins.
module mem_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    // icache side
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    // dcache side
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    // RAM side
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        ramerr
);

    localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] SMAX = STARVE_MAX[CW-1:0];

    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] starve_cnt, starve_cnt_n;

    logic d_req;
    logic xfer_end;
    logic i_starved;

    assign d_req     = dREN | dWEN;
    // ACCESS and ERROR both terminate the granted access
    assign xfer_end  = (ramstate == RS_ACCESS) || (ramstate == RS_ERROR);
    assign i_starved = (starve_cnt == SMAX);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            starve_cnt <= '0;
        end else begin
            state      <= state_n;
            starve_cnt <= starve_cnt_n;
        end
    end

    always_comb begin
        state_n      = state;
        starve_cnt_n = starve_cnt;
        case (state)
            IDLE: begin
                if (d_req && !(iREN && i_starved)) begin
                    state_n = DGNT;
                    // only reachable below SMAX when iREN is high, so no overflow
                    if (iREN) starve_cnt_n = starve_cnt + 1'b1;
                end else if (iREN) begin
                    state_n      = IGNT;
                    starve_cnt_n = '0;
                end
            end
            IGNT:    if (xfer_end || !iREN)  state_n = IDLE;
            DGNT:    if (xfer_end || !d_req) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        ramerr   = 1'b0;
        case (state)
            IGNT: begin
                ramREN  = 1'b1;
                ramaddr = iaddr;
                iwait   = (ramstate != RS_ACCESS);
                ramerr  = (ramstate == RS_ERROR);
            end
            DGNT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                dwait    = (ramstate != RS_ACCESS);
                ramerr   = (ramstate == RS_ERROR);
            end
            default: ;
        endcase
    end

    assign iload = ramload;
    assign dload = ramload;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a transaction-level model predicts every cycle in which
// the RAM port is driven or a wait/err signal fires; a negedge monitor pops and compares.
module tb_mem_arbiter;

    localparam int STARVE_MAX = 4;
    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
    logic [31:0] iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
    logic [1:0]  ramstate = FREE;
    logic        iwait, dwait, ramREN, ramWEN, ramerr;
    logic [31:0] iload, dload, ramaddr, ramstore;

    mem_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .ramerr(ramerr)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          cyc;
        logic        ren, wen, iw, dw, err;
        logic [31:0] addr, store, load;
    } exp_t;

    exp_t  q[$];
    int    n_checks = 0;
    int    n_fail = 0;
    int    cyc = 0;
    string glog = "";

    // model: who holds the port (0 none, 1 icache, 2 dcache) and how many
    // contested arbitrations icache has lost since it was last served
    int owner = 0;
    int lost  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic model_step();
        exp_t e;
        bit   ev;
        e.cyc = cyc; e.load = ramload;
        e.ren = 0; e.wen = 0; e.addr = '0; e.store = '0;
        e.iw = 1; e.dw = 1; e.err = 0; ev = 0;
        if (owner == 1) begin
            e.ren  = 1'b1;
            e.addr = iaddr;
            e.iw   = (ramstate != ACCESS);
            e.err  = (ramstate == ERROR);
            ev     = 1;
            if (ramstate == ACCESS || ramstate == ERROR || !iREN) owner = 0;
        end else if (owner == 2) begin
            e.wen   = dWEN;
            e.ren   = dREN && !dWEN;
            e.addr  = daddr;
            e.store = dstore;
            e.dw    = (ramstate != ACCESS);
            e.err   = (ramstate == ERROR);
            ev      = e.ren || e.wen || !e.dw || e.err;
            if (ramstate == ACCESS || ramstate == ERROR || !(dREN || dWEN)) owner = 0;
        end else begin
            if (iREN && (dREN || dWEN)) begin
                if (lost >= STARVE_MAX) begin owner = 1; lost = 0; end
                else begin owner = 2; lost = lost + 1; end
            end else if (iREN) begin
                owner = 1; lost = 0;
            end else if (dREN || dWEN) begin
                owner = 2;
            end
        end
        if (ev) q.push_back(e);
    endtask

    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                         input logic [31:0] da, input logic [31:0] ds, input logic [1:0] rs);
        @(posedge CLK);
        #1;
        cyc++;
        iREN = ir; iaddr = ia; dREN = dr; dWEN = dw; daddr = da; dstore = ds;
        ramstate = rs; ramload = $urandom;
        model_step();
    endtask

    // asserts reset mid-cycle, checks the immediate effect, releases after the next edge
    task automatic do_reset();
        #1;
        nRST = 1'b0;
        iREN = 0; dREN = 0; dWEN = 0;
        q.delete();
        owner = 0; lost = 0;
        #1;
        check("rst_ramREN", {31'd0, ramREN}, 32'd0);
        check("rst_ramWEN", {31'd0, ramWEN}, 32'd0);
        check("rst_ramaddr", ramaddr, 32'd0);
        check("rst_ramstore", ramstore, 32'd0);
        check("rst_waits", {30'd0, iwait, dwait}, 32'd3);
        check("rst_ramerr", {31'd0, ramerr}, 32'd0);
        @(posedge CLK);
        #2;
        nRST = 1'b1;
    endtask

    always @(negedge CLK) begin
        bit   present;
        exp_t e;
        if (nRST) begin
            present = !iwait || !dwait || ramerr || ramREN || ramWEN;
            while (q.size() > 0 && q[0].cyc < cyc) begin
                e = q.pop_front();
                n_checks++; n_fail++;
                $display("FAIL missed_event: got nothing at cycle %0d, expected ren=%b wen=%b addr=%h iw=%b dw=%b err=%b",
                         e.cyc, e.ren, e.wen, e.addr, e.iw, e.dw, e.err);
            end
            if (present) begin
                n_checks++;
                if (q.size() == 0 || q[0].cyc != cyc) begin
                    n_fail++;
                    $display("FAIL unexpected_event: got ren=%b wen=%b addr=%h iw=%b dw=%b err=%b at cycle %0d, expected none",
                             ramREN, ramWEN, ramaddr, iwait, dwait, ramerr, cyc);
                end else begin
                    e = q.pop_front();
                    if (ramREN !== e.ren || ramWEN !== e.wen || ramaddr !== e.addr ||
                        ramstore !== e.store || iwait !== e.iw || dwait !== e.dw ||
                        ramerr !== e.err || iload !== e.load || dload !== e.load) begin
                        n_fail++;
                        $display("FAIL port_cycle %0d: got ren=%b wen=%b addr=%h st=%h iw=%b dw=%b err=%b il=%h dl=%h, expected ren=%b wen=%b addr=%h st=%h iw=%b dw=%b err=%b ld=%h",
                                 cyc, ramREN, ramWEN, ramaddr, ramstore, iwait, dwait, ramerr, iload, dload,
                                 e.ren, e.wen, e.addr, e.store, e.iw, e.dw, e.err, e.load);
                    end
                end
                if (!iwait) glog = {glog, "I"};
                if (!dwait) glog = {glog, "D"};
            end
        end
    end

    logic        r_ir, r_dr, r_dw;
    logic [31:0] r_ia, r_da, r_ds;
    logic [1:0]  r_rs;
    int          r;

    initial begin
        #1;
        check("init_ramREN", {31'd0, ramREN}, 32'd0);
        check("init_ramaddr", ramaddr, 32'd0);
        check("init_waits", {30'd0, iwait, dwait}, 32'd3);
        check("init_ramerr", {31'd0, ramerr}, 32'd0);
        @(posedge CLK);
        #2;
        nRST = 1'b1;

        // single icache read
        drive(1, 32'h40, 0, 0, 0, 0, FREE);
        drive(1, 32'h40, 0, 0, 0, 0, ACCESS);
        drive(0, 0, 0, 0, 0, 0, FREE);

        // dcache write wins over simultaneous read
        drive(0, 0, 1, 1, 32'h80, 32'hDEADBEEF, FREE);
        drive(0, 0, 1, 1, 32'h80, 32'hDEADBEEF, ACCESS);
        drive(0, 0, 0, 0, 0, 0, FREE);

        // starvation guard under continuous contention
        do_reset();
        glog = "";
        for (int i = 0; i < 20; i++) drive(1, 32'h100, 1, 0, 32'h200, 0, ACCESS);
        drive(0, 0, 0, 0, 0, 0, FREE);
        n_checks++;
        if (glog != "DDDDIDDDDI") begin
            n_fail++;
            $display("FAIL grant_order: got %s, expected DDDDIDDDDI", glog);
        end

        // BUSY x3 then ERROR on a dcache read
        drive(0, 0, 1, 0, 32'h300, 0, FREE);
        for (int i = 0; i < 3; i++) drive(0, 0, 1, 0, 32'h300, 0, BUSY);
        drive(0, 0, 1, 0, 32'h300, 0, ERROR);
        drive(0, 0, 0, 0, 0, 0, FREE);

        // reset during a stalled icache grant
        drive(1, 32'h44, 0, 0, 0, 0, FREE);
        drive(1, 32'h44, 0, 0, 0, 0, BUSY);
        #1;
        check("pre_rst_ramREN", {31'd0, ramREN}, 32'd1);
        do_reset();

        // dcache abort hands the port to the waiting icache
        glog = "";
        drive(1, 32'h50, 1, 0, 32'h60, 0, FREE);
        drive(1, 32'h50, 1, 0, 32'h60, 0, BUSY);
        drive(1, 32'h50, 0, 0, 32'h60, 0, BUSY);
        drive(1, 32'h50, 0, 0, 0, 0, FREE);
        drive(1, 32'h50, 0, 0, 0, 0, ACCESS);
        drive(0, 0, 0, 0, 0, 0, FREE);
        n_checks++;
        if (glog != "I") begin
            n_fail++;
            $display("FAIL abort_handoff: got %s, expected I", glog);
        end

        // randomized traffic with persistent requests
        r_ir = 0; r_dr = 0; r_dw = 0; r_ia = 0; r_da = 0; r_ds = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) begin r_ir = ~r_ir; r_ia = $urandom; end
            if ($urandom_range(0, 7) == 0) begin
                r_dr = 1'($urandom); r_dw = 1'($urandom); r_da = $urandom; r_ds = $urandom;
            end
            r = $urandom_range(0, 9);
            r_rs = (r < 3) ? FREE : (r < 5) ? BUSY : (r < 9) ? ACCESS : ERROR;
            drive(r_ir, r_ia, r_dr, r_dw, r_da, r_ds, r_rs);
            if ($urandom_range(0, 399) == 0) do_reset();
        end
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0, FREE);

        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: STARVE_MAX, default 4, max consecutive dcache grants issued while an icache request waits.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-003 CLK  in  1  system clock, all state on rising edge.
REQ-004 nRST  in  1  asynchronous active-low reset.
REQ-005 iREN  in  1  icache read request.
REQ-006 iaddr  in  32  icache word address.
REQ-007 iwait  out  1  icache stall; low only in the cycle its read completes.
REQ-008 iload  out  32  icache read data; equals ramload.
REQ-009 dREN  in  1  dcache read request.
REQ-010 dWEN  in  1  dcache write request.
REQ-011 daddr  in  32  dcache word address.
REQ-012 dstore  in  32  dcache write data.
REQ-013 dwait  out  1  dcache stall; low only in the cycle its access completes.
REQ-014 dload  out  32  dcache read data; equals ramload.
REQ-015 ramREN  out  1  RAM read strobe.
REQ-016 ramWEN  out  1  RAM write strobe.
REQ-017 ramaddr  out  32  RAM address.
REQ-018 ramstore  out  32  RAM write data.
REQ-019 ramload  in  32  RAM read data.
REQ-020 ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR.
REQ-021 ramerr  out  1  one-cycle pulse when a granted access ends in ERROR.

Function
REQ-022 FSM states: IDLE, IGNT, DGNT; grant held in a register, never re-evaluated mid-access.
REQ-023 IDLE: no request -> stay; only iREN -> IGNT; only dREN|dWEN -> DGNT; both -> DGNT unless starve_cnt == STARVE_MAX, then IGNT.
REQ-024 starve_cnt (width clog2(STARVE_MAX+1)): +1 on each IDLE->DGNT taken while iREN high, saturating at STARVE_MAX; cleared on every IDLE->IGNT.
REQ-025 IGNT: ramREN=1, ramWEN=0, ramaddr=iaddr, ramstore=0.
REQ-026 DGNT: ramaddr=daddr, ramstore=dstore; dWEN high -> ramWEN=1, ramREN=0 (write wins over simultaneous dREN); else ramREN=dREN, ramWEN=0.
REQ-027 IDLE: ramREN=ramWEN=0, ramaddr=0, ramstore=0.
REQ-028 iwait = ~(state==IGNT && ramstate==ACCESS); dwait = ~(state==DGNT && ramstate==ACCESS); combinational.
REQ-029 Granted state with ramstate ACCESS -> IDLE next cycle; wait low for exactly that cycle.
REQ-030 Granted state with ramstate ERROR -> IDLE next cycle, ramerr=1 that cycle, wait stays high; requester retried by normal arbitration.
REQ-031 Granted state with ramstate FREE or BUSY -> hold state and all RAM outputs stable.
REQ-032 Granted requester drops its request (abort) -> IDLE next cycle, no wait pulse, starve_cnt unchanged.
REQ-033 Minimum latency: request seen in IDLE at cycle N, completion no earlier than N+1 (grant cycle with ACCESS).
REQ-034 Back-to-back: after completion, one IDLE cycle always precedes the next grant.
REQ-035 iload and dload both continuously driven with ramload; validity indicated only by wait low.

Reset
REQ-036 nRST low immediately forces: state IDLE, starve_cnt 0, ramREN=ramWEN=0, ramaddr=0, ramstore=0, iwait=dwait=1, ramerr=0.
REQ-037 Reset asserted mid-access aborts it with no wait pulse; the first grant is decided in the first IDLE cycle after release.

Verification
REQ-038 Only iREN, iaddr=0x40, ramstate ACCESS one cycle after grant -> ramREN=1, ramaddr=0x40, iwait low one cycle, iload=ramload.
REQ-039 dREN and dWEN both high, daddr=0x80, dstore=0xDEADBEEF -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF, dwait low on ACCESS.
REQ-040 iREN and dREN held high continuously, ACCESS every grant, STARVE_MAX=4 -> grant sequence D,D,D,D,I,D,D,D,D,I.
REQ-041 DGNT with ramstate BUSY 3 cycles then ERROR -> ramaddr stable, ramerr pulses once, dwait never low, arbiter returns to IDLE.
REQ-042 nRST pulsed low during IGNT with ramstate BUSY -> ramREN drops same cycle, iwait=1, state IDLE, starve_cnt 0.
REQ-043 In DGNT, dREN dropped before ACCESS -> IDLE next cycle, no dwait pulse, pending iREN granted next.
